sensor_poll_scheduler: RTL and testbench

SENSOR_POLL_SCHEDULER -- requirements
Module: sensor_poll_scheduler

---
 rtl/sensor_poll_scheduler.sv | 139 +++++++++++++
 tb/tb_sensor_poll_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_poll_scheduler.sv
// Round-robin poller for four Arduino sensor channels: selects a channel, waits out
// a guard period, collects one ASCII frame and commits it or flags the channel.
module sensor_poll_scheduler #(
    parameter int FRA         = 5,
    parameter int GUARD_CYC   = 1000,
    parameter int TIMEOUT_CYC = 5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  din,
    input  logic        dout_vld,
    output logic [1:0]  add,
    output logic [39:0] temp,
    output logic [39:0] humi,
    output logic [39:0] pres,
    output logic [39:0] forc,
    output logic [3:0]  upd,
    output logic [3:0]  err,
    output logic        busy
);

    localparam int CNT_W   = $clog2(FRA + 1);
    localparam int GUARD_W = $clog2(GUARD_CYC + 1);
    localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(FRA - 1);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYC - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        RECV,
        COMMIT,
        NEXT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [GUARD_W-1:0] guard;
    logic [TIMER_W-1:0] timer;
    logic [39:0]        cache;
    logic               bad;
    logic               char_ok;
    logic               frame_done;

    // Frames carry decimal numbers only: digits and the decimal point.
    assign char_ok    = ((din >= 8'h30) && (din <= 8'h39)) || (din == 8'h2E);
    assign frame_done = dout_vld && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            add   <= '0;
            cnt   <= '0;
            guard <= '0;
            timer <= '0;
            cache <= '0;
            bad   <= 1'b0;
            temp  <= '0;
            humi  <= '0;
            pres  <= '0;
            forc  <= '0;
            upd   <= '0;
            err   <= '0;
            busy  <= 1'b0;
        end else begin
            upd <= '0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= SETTLE;
                        guard <= '0;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (guard == GUARD_LAST) begin
                        state <= RECV;
                        cnt   <= '0;
                        timer <= '0;
                        bad   <= 1'b0;
                    end else begin
                        guard <= guard + 1'b1;
                    end
                end
                RECV: begin
                    if (dout_vld) begin
                        cache[8*(FRA-1-int'(cnt)) +: 8] <= din;
                        cnt <= cnt + 1'b1;
                        bad <= bad | ~char_ok;
                    end
                    // A completing strobe outranks a timeout landing on the same cycle.
                    if (frame_done) begin
                        if (bad || !char_ok) begin
                            err[add] <= 1'b1;
                            state    <= NEXT;
                        end else begin
                            state <= COMMIT;
                        end
                    end else if (timer == TIMER_LAST) begin
                        err[add] <= 1'b1;
                        cache    <= '0;
                        state    <= NEXT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                COMMIT: begin
                    case (add)
                        2'd0:    temp <= cache;
                        2'd1:    humi <= cache;
                        2'd2:    pres <= cache;
                        default: forc <= cache;
                    endcase
                    upd[add] <= 1'b1;
                    err[add] <= 1'b0;
                    state    <= NEXT;
                end
                NEXT: begin
                    add   <= add + 1'b1;
                    guard <= '0;
                    if (en) begin
                        state <= SETTLE;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Directed bench for sensor_poll_scheduler with a short guard and timeout so every
// path (commit, bad frame, timeout, en drop, reset mid-frame) is reached quickly.
module tb_sensor_poll_scheduler;

    localparam int FRA         = 5;
    localparam int GUARD_CYC   = 4;
    localparam int TIMEOUT_CYC = 100;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  din;
    logic        dout_vld;
    logic [1:0]  add;
    logic [39:0] temp;
    logic [39:0] humi;
    logic [39:0] pres;
    logic [39:0] forc;
    logic [3:0]  upd;
    logic [3:0]  err;
    logic        busy;

    int checkCount;
    int errorCount;

    sensor_poll_scheduler #(
        .FRA        (FRA),
        .GUARD_CYC  (GUARD_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .din     (din),
        .dout_vld(dout_vld),
        .add     (add),
        .temp    (temp),
        .humi    (humi),
        .pres    (pres),
        .forc    (forc),
        .upd     (upd),
        .err     (err),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one strobe that the DUT samples on the next rising edge.
    task automatic applyStimulus(input logic [7:0] b);
        din      = b;
        dout_vld = 1'b1;
        @(posedge clk);
        #1;
        dout_vld = 1'b0;
        din      = 8'h00;
    endtask

    // Called just after SETTLE is entered: wait out the guard, then send n bytes.
    task automatic sendFrame(input logic [39:0] f, input int n);
        waitCycles(GUARD_CYC);
        for (int i = 0; i < n; i++) begin
            applyStimulus(f[39-8*i -: 8]);
        end
    endtask

    // After the completing strobe of a good frame: COMMIT, then NEXT.
    task automatic expectCommit(input string tag, input logic [3:0] updExp, input logic [1:0] addNext);
        waitCycles(1);
        checkOutput({tag, "_upd"}, 64'(upd), 64'(updExp));
        waitCycles(1);
        checkOutput({tag, "_upd_clear"}, 64'(upd), 64'h0);
        checkOutput({tag, "_add"}, 64'(add), 64'(addNext));
    endtask

    logic [39:0] f;

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst        = 1'b1;
        en         = 1'b0;
        din        = 8'h00;
        dout_vld   = 1'b0;
        waitCycles(3);
        checkOutput("reset_add", 64'(add), 64'h0);
        checkOutput("reset_temp", 64'(temp), 64'h0);
        checkOutput("reset_upd_err", 64'({upd, err}), 64'h0);
        checkOutput("reset_busy", 64'(busy), 64'h0);
        rst = 1'b0;
        waitCycles(2);
        checkOutput("idle_stays_idle", 64'(busy), 64'h0);

        // First good frame on temp.
        en = 1'b1;
        waitCycles(1);
        checkOutput("settle_busy", 64'(busy), 64'h1);
        f = 40'h312E323334;
        sendFrame(f, 5);
        checkOutput("before_commit_upd", 64'(upd), 64'h0);
        waitCycles(1);
        checkOutput("temp_upd", 64'(upd), 64'h1);
        checkOutput("temp_value", 64'(temp), 64'h312E323334);
        checkOutput("temp_add_hold", 64'(add), 64'h0);
        waitCycles(1);
        checkOutput("temp_upd_clear", 64'(upd), 64'h0);
        checkOutput("temp_add_next", 64'(add), 64'h1);

        // Remaining channels, wrapping back to 0.
        f = 40'h32322E3530;
        sendFrame(f, 5);
        expectCommit("humi", 4'b0010, 2'd2);
        checkOutput("humi_value", 64'(humi), 64'h32322E3530);
        f = 40'h392E383736;
        sendFrame(f, 5);
        expectCommit("pres", 4'b0100, 2'd3);
        checkOutput("pres_value", 64'(pres), 64'h392E383736);
        f = 40'h302E303031;
        sendFrame(f, 5);
        expectCommit("forc", 4'b1000, 2'd0);
        checkOutput("forc_value", 64'(forc), 64'h302E303031);
        checkOutput("round_err", 64'(err), 64'h0);
        checkOutput("temp_held", 64'(temp), 64'h312E323334);

        // Fresh temp, then a short frame on humi that must time out.
        f = 40'h352E353535;
        sendFrame(f, 5);
        expectCommit("temp2", 4'b0001, 2'd1);
        checkOutput("temp2_value", 64'(temp), 64'h352E353535);
        f = 40'h3939393939;
        sendFrame(f, 3);
        waitCycles(TIMEOUT_CYC - 4);
        checkOutput("timeout_edge_err", 64'(err), 64'h0);
        checkOutput("timeout_edge_add", 64'(add), 64'h1);
        waitCycles(1);
        checkOutput("timeout_err", 64'(err), 64'b0010);
        checkOutput("timeout_humi_held", 64'(humi), 64'h32322E3530);
        checkOutput("timeout_upd", 64'(upd), 64'h0);
        waitCycles(1);
        checkOutput("timeout_add", 64'(add), 64'h2);

        // Bad character on pres.
        f = 40'h312E324134;
        sendFrame(f, 5);
        checkOutput("bad_err", 64'(err), 64'b0110);
        checkOutput("bad_upd", 64'(upd), 64'h0);
        waitCycles(1);
        checkOutput("bad_upd_after", 64'(upd), 64'h0);
        checkOutput("bad_pres_held", 64'(pres), 64'h392E383736);
        checkOutput("bad_add", 64'(add), 64'h3);

        // Walk round to humi again; a good frame clears its error.
        f = 40'h372E303030;
        sendFrame(f, 5);
        expectCommit("forc2", 4'b1000, 2'd0);
        f = 40'h342E333231;
        sendFrame(f, 5);
        expectCommit("temp3", 4'b0001, 2'd1);
        f = 40'h36302E3030;
        sendFrame(f, 5);
        expectCommit("humi2", 4'b0010, 2'd2);
        checkOutput("humi2_value", 64'(humi), 64'h36302E3030);
        checkOutput("humi2_err", 64'(err), 64'b0100);

        // Strobe on the last SETTLE cycle is ignored; en dropped after byte 2.
        waitCycles(GUARD_CYC - 1);
        applyStimulus(8'h41);
        f = 40'h332E313431;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) en = 1'b0;
            applyStimulus(f[39-8*i -: 8]);
        end
        waitCycles(1);
        checkOutput("endrop_upd", 64'(upd), 64'b0100);
        checkOutput("endrop_pres", 64'(pres), 64'h332E313431);
        checkOutput("endrop_err", 64'(err), 64'h0);
        waitCycles(1);
        checkOutput("endrop_busy", 64'(busy), 64'h0);
        checkOutput("endrop_add", 64'(add), 64'h3);
        applyStimulus(8'h31);
        waitCycles(3);
        checkOutput("idle_strobe_busy", 64'(busy), 64'h0);
        checkOutput("idle_strobe_upd", 64'(upd), 64'h0);

        // Reset in the middle of a frame, then restart.
        en = 1'b1;
        waitCycles(1);
        f = 40'h312E313131;
        sendFrame(f, 3);
        rst = 1'b1;
        waitCycles(1);
        checkOutput("rst_add", 64'(add), 64'h0);
        checkOutput("rst_channels", 64'(temp | humi | pres | forc), 64'h0);
        checkOutput("rst_upd_err", 64'({upd, err}), 64'h0);
        checkOutput("rst_busy", 64'(busy), 64'h0);
        rst = 1'b0;
        waitCycles(1);
        f = 40'h382E383838;
        sendFrame(f, 5);
        expectCommit("restart", 4'b0001, 2'd1);
        checkOutput("restart_temp", 64'(temp), 64'h382E383838);
        checkOutput("restart_others", 64'(humi | pres | forc), 64'h0);

        en = 1'b0;
        waitCycles(2);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
